// File: rtl/rr_mux_arb.sv
// M-channel arbitrated multiplexer: forced-select, fixed-priority or round-robin
// grant feeding a single-entry registered output stage.
module rr_mux_arb #(
  parameter int N = 1,
  parameter int M = 4,
  localparam int SW = (M > 1) ? $clog2(M) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M*N-1:0] in_data,
  input  logic [M-1:0]   in_valid,
  output logic [M-1:0]   in_ready,
  input  logic [1:0]     mode,
  input  logic [SW-1:0]  select,
  output logic [N-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_chan,
  output logic [SW-1:0]  rr_ptr_dbg
);

  // Handshake: a beat moves on a rising edge when valid and ready are both high
  // on that port; ready never asserts without the matching valid.
  logic [M-1:0]  grant;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] gidx;
  logic [N-1:0]  sel_data;
  logic          found;
  logic          load_en;
  logic          accept;

  assign load_en    = ~out_valid | out_ready;
  assign in_ready   = grant & {M{load_en & ~rst}};
  assign accept     = |in_ready;
  assign rr_ptr_dbg = rr_ptr;

  always_comb begin
    grant = '0;
    found = 1'b0;
    case (mode)
      2'd0: begin
        for (int i = 0; i < M; i++) begin
          if (select == SW'(i)) grant[i] = in_valid[i];
        end
      end
      2'd2: begin
        // First pass covers rr_ptr..M-1; the second wraps to the lowest index.
        for (int i = 0; i < M; i++) begin
          if (!found && in_valid[i] && (SW'(i) >= rr_ptr)) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
        for (int i = 0; i < M; i++) begin
          if (!found && in_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
      default: begin
        for (int i = 0; i < M; i++) begin
          if (!found && in_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    gidx     = '0;
    sel_data = '0;
    for (int i = 0; i < M; i++) begin
      if (grant[i]) begin
        gidx     = SW'(i);
        sel_data = in_data[i*N +: N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (accept) begin
        out_data  <= sel_data;
        out_chan  <= gidx;
        out_valid <= 1'b1;
        rr_ptr    <= (gidx == SW'(M - 1)) ? '0 : gidx + SW'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
